// File: rtl/pulse_capture.sv
// pulse_capture: once per counter period, reports the rise/fall tick of a PWM input sampled
// against the shared period counter. Optional glitch filter: PULSE_CAPTURE_GLITCH_FILTER_EN.

module pulse_capture #(
  parameter int unsigned bitwidth      = 10,
  parameter int unsigned sync_stages   = 2,
  parameter int unsigned filter_length = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [bitwidth-1:0] counter,
  input  logic                signal_in,
  output logic [bitwidth-1:0] captured_rising,
  output logic [bitwidth-1:0] captured_falling,
  output logic                capture_valid,
  output logic                capture_error
);

  if (sync_stages < 2) begin : g_bad_sync
    $error("sync_stages must be at least 2");
  end
  if (filter_length < 2) begin : g_bad_filter
    $error("filter_length must be at least 2");
  end

  // Counter delay matches the generator output register, the synchronizer and the filter.
`ifdef PULSE_CAPTURE_GLITCH_FILTER_EN
  localparam int unsigned Depth = sync_stages + 1 + filter_length;
`else
  localparam int unsigned Depth = sync_stages + 1;
`endif

  typedef enum logic {StWaitPeriod, StMeasure} state_e;

  logic [sync_stages-1:0] sync_q;
  logic                   sync_sig;
  logic                   level;
  logic                   sync_prev_q;
  logic                   rise_det, fall_det;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[sync_stages-2:0], signal_in};
    end
  end

  assign sync_sig = sync_q[sync_stages-1];

`ifdef PULSE_CAPTURE_GLITCH_FILTER_EN
  // Level flips only once the current sample and the previous filter_length-1 all agree.
  logic [filter_length-2:0] hist_q, hist_d;
  logic                     filt_q, filt_d;

  always_comb begin
    hist_d    = hist_q << 1;
    hist_d[0] = sync_sig;
    filt_d    = filt_q;
    if (sync_sig && (&hist_q)) begin
      filt_d = 1'b1;
    end else if (!sync_sig && !(|hist_q)) begin
      filt_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      filt_q <= filt_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync_sig;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_prev_q <= 1'b0;
    end else begin
      sync_prev_q <= level;
    end
  end

  assign rise_det = level & ~sync_prev_q;
  assign fall_det = ~level & sync_prev_q;

  logic [bitwidth-1:0] cnt_pipe_q [Depth];
  logic [bitwidth-1:0] cnt_dly;
  logic [bitwidth-1:0] cnt_dly_prev_q;
  logic                wrap;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        cnt_pipe_q[i] <= '0;
      end
      cnt_dly_prev_q <= '0;
    end else begin
      cnt_pipe_q[0] <= counter;
      for (int unsigned i = 1; i < Depth; i++) begin
        cnt_pipe_q[i] <= cnt_pipe_q[i-1];
      end
      cnt_dly_prev_q <= cnt_dly;
    end
  end

  assign cnt_dly = cnt_pipe_q[Depth-1];
  assign wrap    = cnt_dly < cnt_dly_prev_q;

  state_e              state_q, state_d;
  logic [1:0]          rise_cnt_q, rise_cnt_d, fall_cnt_q, fall_cnt_d;
  logic [bitwidth-1:0] rise_val_q, rise_val_d, fall_val_q, fall_val_d;
  logic                fell_first_q, fell_first_d;
  logic [bitwidth-1:0] cap_rise_q, cap_rise_d, cap_fall_q, cap_fall_d;
  logic                valid_q, valid_d, err_q, err_d;

  always_comb begin
    state_d      = state_q;
    rise_cnt_d   = rise_cnt_q;
    fall_cnt_d   = fall_cnt_q;
    rise_val_d   = rise_val_q;
    fall_val_d   = fall_val_q;
    fell_first_d = fell_first_q;
    cap_rise_d   = cap_rise_q;
    cap_fall_d   = cap_fall_q;
    valid_d      = 1'b0;
    err_d        = err_q;

    unique case (state_q)
      StWaitPeriod: begin
        if (wrap) state_d = StMeasure;
      end
      StMeasure: begin
        if (wrap) begin
          cap_rise_d = rise_val_q;
          cap_fall_d = fall_val_q;
          valid_d    = 1'b1;
          err_d      = !(rise_cnt_q == 2'd1 && fall_cnt_q == 2'd1 && !fell_first_q);
        end
      end
      default: state_d = StWaitPeriod;
    endcase

    if (wrap) begin
      rise_cnt_d   = '0;
      fall_cnt_d   = '0;
      rise_val_d   = '0;
      fall_val_d   = '0;
      fell_first_d = 1'b0;
    end

    // An edge coinciding with the wrap belongs to the period that is just starting.
    if (state_d == StMeasure) begin
      if (rise_det) begin
        rise_val_d = cnt_dly;
        if (rise_cnt_d != 2'd2) rise_cnt_d = rise_cnt_d + 2'd1;
      end
      if (fall_det) begin
        fall_val_d = cnt_dly;
        if (rise_cnt_d == 2'd0) fell_first_d = 1'b1;
        if (fall_cnt_d != 2'd2) fall_cnt_d = fall_cnt_d + 2'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StWaitPeriod;
      rise_cnt_q   <= '0;
      fall_cnt_q   <= '0;
      rise_val_q   <= '0;
      fall_val_q   <= '0;
      fell_first_q <= 1'b0;
      cap_rise_q   <= '0;
      cap_fall_q   <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rise_cnt_q   <= rise_cnt_d;
      fall_cnt_q   <= fall_cnt_d;
      rise_val_q   <= rise_val_d;
      fall_val_q   <= fall_val_d;
      fell_first_q <= fell_first_d;
      cap_rise_q   <= cap_rise_d;
      cap_fall_q   <= cap_fall_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
    end
  end

  assign captured_rising  = cap_rise_q;
  assign captured_falling = cap_fall_q;
  assign capture_valid    = valid_q;
  assign capture_error    = err_q;

endmodule

// File: tb/tb_pulse_capture.sv
// tb_pulse_capture: directed loopback scenarios for pulse_capture with a modelled registered
// PWM generator driving signal_in from the same counter.

module tb_pulse_capture;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] counter;
  logic       signal_in;
  logic [9:0] captured_rising, captured_falling;
  logic       capture_valid, capture_error;

  int nchecks = 0;
  int nerrors = 0;

  int cnt;
  int pr0, pf0, pr1, pf1, pr2, pf2;
  int nvalid;
  logic [9:0] last_r, last_f;
  logic       last_e;

  pulse_capture #(
    .bitwidth     (10),
    .sync_stages  (2),
    .filter_length(3)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .counter         (counter),
    .signal_in       (signal_in),
    .captured_rising (captured_rising),
    .captured_falling(captured_falling),
    .capture_valid   (capture_valid),
    .capture_error   (capture_error)
  );

  always #5 clock = ~clock;

  // Combinational generator level at tick x; the generator registers it one cycle later.
  function automatic logic gen_level(input int x);
    return (x >= pr0 && x < pf0) || (x >= pr1 && x < pf1) || (x >= pr2 && x < pf2);
  endfunction

  task automatic set_pat(input int r0, input int f0, input int r1, input int f1,
                         input int r2, input int f2);
    pr0 = r0; pf0 = f0; pr1 = r1; pf1 = f1; pr2 = r2; pf2 = f2;
  endtask

  task automatic run(input int n, input bit stall);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (capture_valid === 1'b1) begin
        nvalid++;
        last_r = captured_rising;
        last_f = captured_falling;
        last_e = capture_error;
      end
      if (!stall) begin
        counter   = 10'(cnt % 1024);
        signal_in = gen_level((cnt + 1023) % 1024);
        cnt++;
      end
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    cnt       = 0;
    counter   = 10'd0;
    signal_in = gen_level(1023);
    repeat (3) @(negedge clock);
    reset  = 1'b0;
    nvalid = 0;
  endtask

  // Reset, then three counter periods: first discarded, two published.
  task automatic run_three_periods(input string name, input logic [9:0] er, input logic [9:0] ef,
                                   input logic ee);
    do_reset();
    run(3 * 1024 + 20, 1'b0);
    nchecks++;
    if (nvalid !== 2) begin
      $display("FAIL %s valid_count got %0d want 2", name, nvalid); nerrors++;
    end
    nchecks++;
    if (last_r !== er) begin
      $display("FAIL %s rising got %0d want %0d", name, last_r, er); nerrors++;
    end
    nchecks++;
    if (last_f !== ef) begin
      $display("FAIL %s falling got %0d want %0d", name, last_f, ef); nerrors++;
    end
    nchecks++;
    if (last_e !== ee) begin
      $display("FAIL %s error got %0b want %0b", name, last_e, ee); nerrors++;
    end
  endtask

  task automatic test_reset();
    set_pat(0, 0, 0, 0, 0, 0);
    reset = 1'b1; counter = 10'd0; signal_in = 1'b0;
    #12;
    nchecks++;
    if (captured_rising !== 10'd0) begin
      $display("FAIL reset_rising got %0d want 0", captured_rising); nerrors++;
    end
    nchecks++;
    if (captured_falling !== 10'd0) begin
      $display("FAIL reset_falling got %0d want 0", captured_falling); nerrors++;
    end
    nchecks++;
    if (capture_valid !== 1'b0) begin
      $display("FAIL reset_valid got %0b want 0", capture_valid); nerrors++;
    end
    nchecks++;
    if (capture_error !== 1'b0) begin
      $display("FAIL reset_error got %0b want 0", capture_error); nerrors++;
    end
  endtask

  task automatic test_loopback();
    set_pat(100, 300, 0, 0, 0, 0);
    run_three_periods("loopback", 10'd100, 10'd300, 1'b0);
  endtask

  task automatic test_rise_at_zero();
    set_pat(0, 512, 0, 0, 0, 0);
    run_three_periods("rise_zero", 10'd0, 10'd512, 1'b0);
  endtask

  task automatic test_const_low();
    set_pat(0, 0, 0, 0, 0, 0);
    run_three_periods("const_low", 10'd0, 10'd0, 1'b1);
  endtask

  task automatic test_two_pulses();
    set_pat(100, 200, 400, 500, 0, 0);
    run_three_periods("two_pulses", 10'd400, 10'd500, 1'b1);
  endtask

  task automatic test_glitch();
    set_pat(100, 300, 600, 602, 0, 0);
`ifdef PULSE_CAPTURE_GLITCH_FILTER_EN
    run_three_periods("glitch", 10'd100, 10'd300, 1'b0);
`else
    run_three_periods("glitch", 10'd600, 10'd602, 1'b1);
`endif
  endtask

  task automatic test_stall();
    set_pat(100, 300, 0, 0, 0, 0);
    run_three_periods("pre_stall", 10'd100, 10'd300, 1'b0);
    nvalid = 0;
    run(1500, 1'b1);
    nchecks++;
    if (nvalid !== 0) begin
      $display("FAIL stall_valid_count got %0d want 0", nvalid); nerrors++;
    end
    nchecks++;
    if (captured_rising !== 10'd100 || captured_falling !== 10'd300) begin
      $display("FAIL stall_hold got %0d/%0d want 100/300", captured_rising, captured_falling);
      nerrors++;
    end
  endtask

  task automatic test_reset_mid();
    set_pat(100, 300, 0, 0, 0, 0);
    run_three_periods("pre_reset", 10'd100, 10'd300, 1'b0);
    for (int i = 0; i < 1100 && ((cnt + 1023) % 1024) != 250; i++) run(1, 1'b0);
    #2 reset = 1'b1;
    #1;
    nchecks++;
    if (captured_rising !== 10'd0 || captured_falling !== 10'd0) begin
      $display("FAIL mid_reset_outputs got %0d/%0d want 0/0", captured_rising, captured_falling);
      nerrors++;
    end
    nchecks++;
    if (capture_valid !== 1'b0 || capture_error !== 1'b0) begin
      $display("FAIL mid_reset_flags got %0b/%0b want 0/0", capture_valid, capture_error);
      nerrors++;
    end
    nvalid = 0;
    run(2, 1'b0);
    reset = 1'b0;
    run(800, 1'b0);
    nchecks++;
    if (nvalid !== 0) begin
      $display("FAIL mid_reset_discard got %0d valids want 0", nvalid); nerrors++;
    end
    run(1024, 1'b0);
    nchecks++;
    if (nvalid !== 1) begin
      $display("FAIL mid_reset_first got %0d valids want 1", nvalid); nerrors++;
    end
    nchecks++;
    if (last_r !== 10'd100 || last_f !== 10'd300 || last_e !== 1'b0) begin
      $display("FAIL mid_reset_values got %0d/%0d/%0b want 100/300/0", last_r, last_f, last_e);
      nerrors++;
    end
  endtask

  initial begin
    nvalid = 0;
    last_r = '0; last_f = '0; last_e = 1'b0;
    test_reset();
    test_loopback();
    test_rise_at_zero();
    test_const_low();
    test_two_pulses();
    test_glitch();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
